// File: rtl/menu_ctrl.sv
// rtl/menu_ctrl.sv - keyboard-driven menu page/cursor controller with frame-synced display shadow
module menu_ctrl #(
  parameter int LOCKOUT_FRAMES = 4,
  parameter int ROW_FIRST      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       new_frame,
  output logic [1:0] page_sel,
  output logic [3:0] cursor_row,
  output logic [1:0] difficulty,
  output logic       game_active,
  output logic       game_start
);

  typedef enum logic [1:0] {
    MAIN     = 2'd0,
    OPTIONS  = 2'd1,
    CONTROLS = 2'd2,
    GAME     = 2'd3
  } state_t;

  localparam logic [7:0] K_W   = 8'h57;
  localparam logic [7:0] K_S   = 8'h53;
  localparam logic [7:0] K_A   = 8'h41;
  localparam logic [7:0] K_D   = 8'h44;
  localparam logic [7:0] K_ENT = 8'h0D;
  localparam logic [7:0] K_ESC = 8'h1B;

  // Counter wide enough to hold LOCKOUT_FRAMES; one bit minimum when lockout is disabled.
  localparam int LW = (LOCKOUT_FRAMES > 0) ? $clog2(LOCKOUT_FRAMES + 1) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_FRAMES);
  localparam logic [3:0]    ROW_BASE  = 4'(ROW_FIRST);

  state_t        state, nxt_state;
  logic [1:0]    cur, nxt_cur;
  logic [1:0]    diff, nxt_diff;
  logic [LW-1:0] lock_cnt;
  logic          hit, start, accept;

  // Decode the key against the current page: hit marks keys that mean something here.
  always_comb begin
    nxt_state = state;
    nxt_cur   = cur;
    nxt_diff  = diff;
    hit       = 1'b0;
    start     = 1'b0;
    case (state)
      MAIN: begin
        case (key_code)
          K_W: begin
            hit     = 1'b1;
            nxt_cur = (cur == 2'd0) ? 2'd0 : cur - 2'd1;
          end
          K_S: begin
            hit     = 1'b1;
            nxt_cur = (cur >= 2'd2) ? 2'd2 : cur + 2'd1;
          end
          K_ENT: begin
            hit = 1'b1;
            case (cur)
              2'd0: begin
                nxt_state = GAME;
                start     = 1'b1;
              end
              2'd1: begin
                nxt_state = OPTIONS;
                nxt_cur   = 2'd0;
              end
              default: nxt_state = CONTROLS;
            endcase
          end
          default: ;
        endcase
      end
      OPTIONS: begin
        case (key_code)
          K_W: begin
            hit     = 1'b1;
            nxt_cur = 2'd0;
          end
          K_S: begin
            hit     = 1'b1;
            nxt_cur = 2'd1;
          end
          K_D: if (cur == 2'd0) begin
            hit      = 1'b1;
            nxt_diff = (diff == 2'd3) ? 2'd3 : diff + 2'd1;
          end
          K_A: if (cur == 2'd0) begin
            hit      = 1'b1;
            nxt_diff = (diff == 2'd0) ? 2'd0 : diff - 2'd1;
          end
          K_ENT: if (cur == 2'd1) begin
            hit       = 1'b1;
            nxt_state = MAIN;
            nxt_cur   = 2'd1;
          end
          K_ESC: begin
            hit       = 1'b1;
            nxt_state = MAIN;
            nxt_cur   = 2'd1;
          end
          default: ;
        endcase
      end
      CONTROLS: begin
        if (key_code == K_ESC || key_code == K_ENT) begin
          hit       = 1'b1;
          nxt_state = MAIN;
          nxt_cur   = 2'd2;
        end
      end
      default: begin
        if (key_code == K_ESC) begin
          hit       = 1'b1;
          nxt_state = MAIN;
          nxt_cur   = 2'd0;
        end
      end
    endcase
    accept = key_valid && (lock_cnt == '0) && hit;
  end

  // Menu state, lockout and display shadow; the shadow samples pre-key values on a coincident frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= MAIN;
      cur        <= 2'd0;
      diff       <= 2'd1;
      lock_cnt   <= '0;
      page_sel   <= 2'd0;
      cursor_row <= ROW_BASE;
      game_start <= 1'b0;
    end else begin
      game_start <= accept && start;
      if (accept) begin
        state    <= nxt_state;
        cur      <= nxt_cur;
        diff     <= nxt_diff;
        lock_cnt <= LOCK_LOAD;
      end else if (new_frame && lock_cnt != '0) begin
        lock_cnt <= lock_cnt - LW'(1);
      end
      if (new_frame) begin
        page_sel   <= state;
        cursor_row <= (state == MAIN || state == OPTIONS) ? ROW_BASE + {2'b00, cur} : 4'hF;
      end
    end
  end

  assign difficulty  = diff;
  assign game_active = (state == GAME);

endmodule

// File: tb/tb_menu_ctrl.sv
// tb/tb_menu_ctrl.sv - directed table-driven bench for menu_ctrl
module tb_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       new_frame;
  logic [1:0] page_sel;
  logic [3:0] cursor_row;
  logic [1:0] difficulty;
  logic       game_active;
  logic       game_start;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [7:0] K_W   = 8'h57;
  localparam logic [7:0] K_S   = 8'h53;
  localparam logic [7:0] K_A   = 8'h41;
  localparam logic [7:0] K_D   = 8'h44;
  localparam logic [7:0] K_ENT = 8'h0D;
  localparam logic [7:0] K_ESC = 8'h1B;

  typedef struct {
    logic [7:0] code;
    logic [1:0] page;
    logic [3:0] row;
    logic [1:0] diff;
    logic       act;
  } vec_t;

  vec_t vecs [27];

  menu_ctrl #(.LOCKOUT_FRAMES(4), .ROW_FIRST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .new_frame  (new_frame),
    .page_sel   (page_sel),
    .cursor_row (cursor_row),
    .difficulty (difficulty),
    .game_active(game_active),
    .game_start (game_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic [1:0] p, input logic [3:0] r,
                           input logic [1:0] d, input logic a);
    check({name, ".page"}, {6'd0, page_sel}, {6'd0, p});
    check({name, ".row"},  {4'd0, cursor_row}, {4'd0, r});
    check({name, ".diff"}, {6'd0, difficulty}, {6'd0, d});
    check({name, ".act"},  {7'd0, game_active}, {7'd0, a});
  endtask

  task automatic key(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_code  = 8'h00;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      new_frame = 1'b1;
      @(posedge clk); #1;
      new_frame = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vecs[0]  = '{K_S,   2'd0, 4'd5, 2'd1, 1'b0};
    vecs[1]  = '{K_S,   2'd0, 4'd6, 2'd1, 1'b0};
    vecs[2]  = '{K_S,   2'd0, 4'd6, 2'd1, 1'b0};
    vecs[3]  = '{K_S,   2'd0, 4'd6, 2'd1, 1'b0};
    vecs[4]  = '{K_W,   2'd0, 4'd5, 2'd1, 1'b0};
    vecs[5]  = '{K_W,   2'd0, 4'd4, 2'd1, 1'b0};
    vecs[6]  = '{K_ENT, 2'd3, 4'hF, 2'd1, 1'b1};
    vecs[7]  = '{K_ESC, 2'd0, 4'd4, 2'd1, 1'b0};
    vecs[8]  = '{K_S,   2'd0, 4'd5, 2'd1, 1'b0};
    vecs[9]  = '{K_ENT, 2'd1, 4'd4, 2'd1, 1'b0};
    vecs[10] = '{K_D,   2'd1, 4'd4, 2'd2, 1'b0};
    vecs[11] = '{K_D,   2'd1, 4'd4, 2'd3, 1'b0};
    vecs[12] = '{K_D,   2'd1, 4'd4, 2'd3, 1'b0};
    vecs[13] = '{K_D,   2'd1, 4'd4, 2'd3, 1'b0};
    vecs[14] = '{K_A,   2'd1, 4'd4, 2'd2, 1'b0};
    vecs[15] = '{K_A,   2'd1, 4'd4, 2'd1, 1'b0};
    vecs[16] = '{K_A,   2'd1, 4'd4, 2'd0, 1'b0};
    vecs[17] = '{K_A,   2'd1, 4'd4, 2'd0, 1'b0};
    vecs[18] = '{K_S,   2'd1, 4'd5, 2'd0, 1'b0};
    vecs[19] = '{K_D,   2'd1, 4'd5, 2'd0, 1'b0};
    vecs[20] = '{K_ENT, 2'd0, 4'd5, 2'd0, 1'b0};
    vecs[21] = '{K_S,   2'd0, 4'd6, 2'd0, 1'b0};
    vecs[22] = '{K_ENT, 2'd2, 4'hF, 2'd0, 1'b0};
    vecs[23] = '{K_W,   2'd2, 4'hF, 2'd0, 1'b0};
    vecs[24] = '{K_ESC, 2'd0, 4'd6, 2'd0, 1'b0};
    vecs[25] = '{8'h58, 2'd0, 4'd6, 2'd0, 1'b0};
    vecs[26] = '{K_D,   2'd0, 4'd6, 2'd0, 1'b0};

    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    new_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 2'd0, 4'd4, 2'd1, 1'b0);
    check("reset.start", {7'd0, game_start}, 8'd0);
    rst = 1'b1;
    frames(1);
    check_all("first_frame", 2'd0, 4'd4, 2'd1, 1'b0);

    for (int i = 0; i < 27; i++) begin
      key(vecs[i].code);
      frames(5);
      check_all($sformatf("vec%0d", i), vecs[i].page, vecs[i].row, vecs[i].diff, vecs[i].act);
    end

    // Lockout: second W one frame later is dropped (MAIN cur2 -> cur1 only).
    key(K_W);
    frames(1);
    key(K_W);
    frames(5);
    check("lockout.row", {4'd0, cursor_row}, 8'd5);

    // Game entry/exit pulse timing.
    key(K_W);
    frames(5);
    key(K_ENT);
    check("gstart.pulse", {7'd0, game_start}, 8'd1);
    check("gstart.active", {7'd0, game_active}, 8'd1);
    check("gstart.page_held", {6'd0, page_sel}, 8'd0);
    @(posedge clk); #1;
    check("gstart.pulse_end", {7'd0, game_start}, 8'd0);
    frames(5);
    check("game.page", {6'd0, page_sel}, 8'd3);
    check("game.row", {4'd0, cursor_row}, 8'h0F);
    key(K_ESC);
    check("gexit.active", {7'd0, game_active}, 8'd0);
    frames(5);
    check_all("gexit", 2'd0, 4'd4, 2'd0, 1'b0);

    // Difficulty changes the cycle after the accepted key.
    key(K_S);
    frames(5);
    key(K_ENT);
    frames(5);
    key(K_D);
    check("diff.d1", {6'd0, difficulty}, 8'd1);
    frames(5);
    key(K_D);
    check("diff.d2", {6'd0, difficulty}, 8'd2);
    frames(5);
    key(K_ESC);
    frames(5);
    check_all("opt_esc", 2'd0, 4'd5, 2'd2, 1'b0);

    // Key and frame coincide: shadow takes pre-key cursor.
    key_valid = 1'b1;
    key_code  = K_S;
    new_frame = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    new_frame = 1'b0;
    check("coinc.row_old", {4'd0, cursor_row}, 8'd5);
    frames(1);
    check("coinc.row_new", {4'd0, cursor_row}, 8'd6);
    frames(5);

    // Enter GAME, then asynchronous reset mid-cycle.
    key(K_W);
    frames(5);
    key(K_W);
    frames(5);
    key(K_ENT);
    frames(5);
    check_all("pre_rst", 2'd3, 4'hF, 2'd2, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_rst", 2'd0, 4'd4, 2'd1, 1'b0);
    check("async_rst.start", {7'd0, game_start}, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold", 2'd0, 4'd4, 2'd1, 1'b0);
    frames(1);
    check_all("rst_frame", 2'd0, 4'd4, 2'd1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
